debug_wb_bridge: RTL and testbench
==================================

Name: debug_wb_bridge

Overview:
Command sequencer between the debug UART byte stream and a Wishbone master port on the management SoC bus. It parses host command frames from the UART receiver, issues single-word Wishbone read or write cycles with auto-incrementing address, and streams read data back to the UART transmitter. It lets a bench or host inspect and patch memory and CSRs while the CPU runs from flash.

Parameters:
CMD_WRITE, 8'h01, command byte that selects a burst write.
CMD_READ, 8'h02, command byte that selects a burst read.
TIMEOUT_CYCLES, 1024, core_clk cycles to wait for wb_ack_i before abort (used only with the optional feature).

Ports:
core_clk  input  1  system clock; all logic on rising edge.
core_rstn  input  1  asynchronous active-low reset.
rx_data  input  8  byte from the UART receiver.
rx_valid  input  1  rx_data valid.
rx_ready  output  1  bridge accepts rx_data this cycle.
tx_data  output  8  byte to the UART transmitter.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  transmitter accepts tx_data.
wb_adr_o  output  32  Wishbone byte address, word aligned.
wb_dat_o  output  32  Wishbone write data.
wb_dat_i  input  32  Wishbone read data.
wb_sel_o  output  4  byte select; always 4'hF when wb_stb_o=1.
wb_we_o  output  1  write enable.
wb_cyc_o  output  1  bus cycle.
wb_stb_o  output  1  strobe.
wb_ack_i  input  1  slave acknowledge.
busy  output  1  high whenever state != IDLE.
err  output  1  sticky error flag; cleared by reset or a new valid command byte.

Behaviour:
- Frame: CMD(1) LEN(1) ADDR(4, MSB first) then, for write, LEN x 4 data bytes, MSB first. A read returns LEN x 4 bytes, MSB first.
- Reset: all outputs 0; state IDLE; address, count and shift registers 0.
- RX handshake: a byte transfers when rx_valid && rx_ready. rx_ready=1 only in IDLE, LEN, ADDR, WDATA.
- TX handshake: a byte transfers when tx_valid && tx_ready. tx_data holds stable while tx_valid=1 and !tx_ready.
- States:
  - IDLE: byte == CMD_WRITE or CMD_READ -> latch cmd, clear err, go to LEN. Any other byte is dropped; stay IDLE.
  - LEN: latch count. count == 0 -> IDLE with no bus cycle. Otherwise go to ADDR.
  - ADDR: shift 4 bytes. On the 4th byte, force addr[1:0] = 0. Write -> WDATA; read -> WB_RD.
  - WDATA: shift 4 bytes into wb_dat_o. On the 4th byte -> WB_WR.
  - WB_WR / WB_RD: assert cyc, stb, sel=F; we=1 only for WB_WR. Hold until wb_ack_i, then deassert all in the next cycle.
    - On ack, WB_RD latches wb_dat_i and goes to TX.
    - On ack, WB_WR decrements count and increments addr by 4. Then count != 0 -> WDATA; else IDLE.
  - TX: send latched word bytes [31:24] to [7:0]. After the 4th accepted byte, decrement count and increment addr by 4. Then count != 0 -> WB_RD; else IDLE.
- Address wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Bus rules:
  - At most one outstanding cycle.
  - wb_cyc_o == wb_stb_o at all times.
  - The first assertion of stb occurs 1 cycle after the last frame byte.
- wb_ack_i outside a cycle is ignored.
- Reset asserted mid-frame or mid-cycle: outputs drop to 0 asynchronously and the partial frame is discarded.

Optional Feature:
DEBUG_WB_BRIDGE_TIMEOUT_EN.
- Defined: a counter runs while wb_cyc_o=1. If it reaches TIMEOUT_CYCLES without ack, the bridge:
  - deasserts cyc/stb;
  - sets err=1;
  - for a read, transmits 32'hDEAD_BEEF for that word and continues;
  - for a write, discards the remaining data bytes of the frame in a DRAIN state that accepts and drops them, then goes to IDLE.
- Undefined: no counter and no DRAIN state; the bridge waits for ack indefinitely; err stays 0.

Test Plan:
- Write then read back:
  - stimulus: send 01 01 30 00 00 00 12 34 56 78;
  - required: one write with adr=3000_0000, dat=1234_5678, sel=F;
  - then send 02 01 30 00 00 00; required: tx bytes 12 34 56 78.
- Burst read: send 02 03 00 00 00 10 -> reads at 0x10, 0x14, 0x18 in order; 12 tx bytes; busy low after the last byte.
- Frame edge cases:
  - send 02 00 -> no bus cycle, back to IDLE;
  - send 7F -> dropped;
  - send 02 01 00 00 00 13 -> wb_adr_o=0000_0010.
- Backpressure and slow slave:
  - stimulus: tx_ready low 50 cycles mid-word; ack delayed 7 cycles;
  - required: tx_data stable, no lost or repeated byte, stb held 7 cycles.
- Reset mid-frame: assert core_rstn low after 3 address bytes -> all outputs 0; a following full read frame completes correctly.
- With DEBUG_WB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack:
  - stimulus: 2-word read;
  - required: err=1, tx DE AD BE EF twice, cyc low after 16 cycles each.

Source files
------------

// File: rtl/debug_wb_bridge_if.sv
// debug_wb_bridge_if: UART byte streams and Wishbone master signals of the debug bridge
interface debug_wb_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    output rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    input  rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/debug_wb_bridge.sv
// debug_wb_bridge: UART command frames to single-word Wishbone cycles; DEBUG_WB_BRIDGE_TIMEOUT_EN adds a bus timeout
module debug_wb_bridge #(
  parameter logic [7:0] CMD_WRITE = 8'h01,
  parameter logic [7:0] CMD_READ  = 8'h02,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, LEN, ADDR, WDATA, WB_WR, WB_RD, TX
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;
  state_t      state_q, state_d;
  logic        rd_q, rd_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        cyc, rx_fire, tx_fire;
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo;
  assign tmo = tmo_q == TW'(TIMEOUT_CYCLES - 1);
`endif
  assign cyc     = state_q == WB_WR || state_q == WB_RD;
  assign rx_fire = rx_valid && rdy_q;
  assign tx_fire = state_q == TX && tx_ready;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: if (rx_fire && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
        rd_d    = rx_data == CMD_READ;
        err_d   = 1'b0;
        state_d = LEN;
      end
      LEN: if (rx_fire) begin
        cnt_d   = rx_data;
        bcnt_d  = 2'd0;
        state_d = rx_data == 8'd0 ? IDLE : ADDR;
      end
      ADDR: if (rx_fire) begin
        adr_d  = {adr_q[23:0], rx_data};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          adr_d[1:0] = 2'b00;
          state_d    = rd_q ? WB_RD : WDATA;
        end
      end
      WDATA: if (rx_fire) begin
        dat_d  = {dat_q[23:0], rx_data};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = WB_WR;
      end
      WB_WR: if (wb_ack_i) begin
        cnt_d   = cnt_q - 8'd1;
        adr_d   = adr_q + 32'd4;
        state_d = cnt_q == 8'd1 ? IDLE : WDATA;
      end
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
      else if (tmo) begin
        err_d   = 1'b1;
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd1 ? IDLE : DRAIN;
      end
`endif
      WB_RD: if (wb_ack_i) begin
        dat_d   = wb_dat_i;
        state_d = TX;
      end
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
      else if (tmo) begin
        dat_d   = 32'hDEAD_BEEF;
        err_d   = 1'b1;
        state_d = TX;
      end
`endif
      TX: if (tx_fire) begin
        dat_d  = {dat_q[23:0], 8'h00};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          cnt_d   = cnt_q - 8'd1;
          adr_d   = adr_q + 32'd4;
          state_d = cnt_q == 8'd1 ? IDLE : WB_RD;
        end
      end
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
      DRAIN: if (rx_fire) begin
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          cnt_d   = cnt_q - 8'd1;
          state_d = cnt_q == 8'd1 ? IDLE : DRAIN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
    tmo_d = (cyc && state_d == state_q) ? tmo_q + 1'b1 : '0;
    rdy_d = state_d inside {IDLE, LEN, ADDR, WDATA, DRAIN};
`else
    rdy_d = state_d inside {IDLE, LEN, ADDR, WDATA};
`endif
  end
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      bcnt_q  <= bcnt_d;
    end
  end
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`endif
  assign rx_ready = rdy_q;
  assign tx_valid = state_q == TX;
  assign tx_data  = dat_q[31:24];
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = state_q == WB_WR;
  assign wb_sel_o = {4{cyc}};
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign busy     = state_q != IDLE;
  assign err      = err_q;
endmodule

// File: tb/tb_debug_wb_bridge.sv
// tb_debug_wb_bridge: directed frames with a Wishbone slave model and scoreboarded bus cycles and tx bytes
module tb_debug_wb_bridge;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_t;

  logic core_clk, core_rstn, busy, err;
  debug_wb_bridge_if bus();

  int checks = 0, failures = 0;
  int tx_cnt = 0, ack_dly = 1, wcnt = 0, run = 0, last_run = 0;
  logic no_ack = 1'b0, stray = 1'b0, ack_r = 1'b0, held_v = 1'b0;
  logic [7:0] held = '0;
  wb_t exp_wb[$];
  logic [7:0] exp_tx[$];
  logic [31:0] mem [logic [31:0]];

  assign bus.wb_ack_i = ack_r | stray;

  debug_wb_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .rx_data(bus.rx_data), .rx_valid(bus.rx_valid), .rx_ready(bus.rx_ready),
    .tx_data(bus.tx_data), .tx_valid(bus.tx_valid), .tx_ready(bus.tx_ready),
    .wb_adr_o(bus.wb_adr_o), .wb_dat_o(bus.wb_dat_o), .wb_dat_i(bus.wb_dat_i),
    .wb_sel_o(bus.wb_sel_o), .wb_we_o(bus.wb_we_o), .wb_cyc_o(bus.wb_cyc_o),
    .wb_stb_o(bus.wb_stb_o), .wb_ack_i(bus.wb_ack_i), .busy(busy), .err(err)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5C3_0F96;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [31:0] d);
    exp_wb.push_back('{we: 1'b0, adr: a, dat: 32'h0});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_wb.push_back('{we: 1'b1, adr: a, dat: d});
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge core_clk);
    while (!bus.rx_ready && n < 2000) begin
      @(negedge core_clk);
      n++;
    end
    chk("rx_accept", 64'(n < 2000), 64'd1);
    @(posedge core_clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] a);
    send(cmd);
    send(len);
    send_word(a);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge core_clk);
    while ((busy || exp_wb.size() != 0 || exp_tx.size() != 0) && n < 5000) begin
      @(negedge core_clk);
      n++;
    end
    chk(tag, 64'(n < 5000), 64'd1);
    @(posedge core_clk);
    #1;
  endtask

  initial begin
    wb_t e;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge core_clk);
      #1;
      if (ack_r) begin
        ack_r = 1'b0;
        wcnt  = 0;
      end else if (bus.wb_stb_o && !no_ack) begin
        if (wcnt == ack_dly - 1) begin
          chk("wb_expected", 64'(exp_wb.size() != 0), 64'd1);
          if (exp_wb.size() != 0) begin
            e = exp_wb.pop_front();
            chk("wb_we", 64'(bus.wb_we_o), 64'(e.we));
            chk("wb_adr", 64'(bus.wb_adr_o), 64'(e.adr));
            chk("wb_sel", 64'(bus.wb_sel_o), 64'hF);
            if (e.we) chk("wb_dat", 64'(bus.wb_dat_o), 64'(e.dat));
          end
          if (bus.wb_we_o) mem[bus.wb_adr_o] = bus.wb_dat_o;
          else bus.wb_dat_i = mem.exists(bus.wb_adr_o) ? mem[bus.wb_adr_o] : pat(bus.wb_adr_o);
          ack_r = 1'b1;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  initial begin
    forever begin
      @(negedge core_clk);
      if (bus.tx_valid && held_v) chk("tx_stable", 64'(bus.tx_data), 64'(held));
      held_v = bus.tx_valid && !bus.tx_ready;
      held   = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0) chk("tx_byte", 64'(bus.tx_data), 64'(exp_tx.pop_front()));
        tx_cnt++;
      end
      chk("cyc_eq_stb", 64'(bus.wb_cyc_o), 64'(bus.wb_stb_o));
      if (bus.wb_stb_o) begin
        chk("sel_full", 64'(bus.wb_sel_o), 64'hF);
        run++;
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    int n, base;
    core_rstn    = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_wb", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o}), 64'd0);
    chk("rst_misc", 64'({bus.wb_dat_o, bus.tx_valid, bus.tx_data, bus.rx_ready, busy, err}), 64'd0);
    #3 core_rstn = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    exp_wr(32'h3000_0000, 32'h1234_5678);
    frame(8'h01, 8'h01, 32'h3000_0000);
    send(8'h12);
    send(8'h34);
    send(8'h56);
    chk("stb_before_last", 64'(bus.wb_stb_o), 64'd0);
    send(8'h78);
    chk("stb_latency", 64'(bus.wb_stb_o), 64'd1);
    wait_idle("wr1_done");
    exp_rd(32'h3000_0000, 32'h1234_5678);
    frame(8'h02, 8'h01, 32'h3000_0000);
    wait_idle("rd1_done");
    for (int i = 0; i < 3; i++) exp_rd(32'h10 + 32'(4 * i), pat(32'h10 + 32'(4 * i)));
    frame(8'h02, 8'h03, 32'h0000_0010);
    wait_idle("burst_done");
    chk("burst_busy", 64'(busy), 64'd0);
    send(8'h02);
    send(8'h00);
    chk("len0_idle", 64'(busy), 64'd0);
    send(8'h7F);
    chk("bad_cmd_idle", 64'(busy), 64'd0);
    exp_rd(32'h10, pat(32'h10));
    frame(8'h02, 8'h01, 32'h0000_0013);
    chk("adr_aligned", 64'(bus.wb_adr_o), 64'h10);
    wait_idle("unaligned_done");
    exp_wr(32'hFFFF_FFFC, 32'hA5A5_0001);
    exp_wr(32'h0000_0000, 32'h5A5A_0002);
    frame(8'h01, 8'h02, 32'hFFFF_FFFC);
    send_word(32'hA5A5_0001);
    send_word(32'h5A5A_0002);
    wait_idle("wrap_wr_done");
    exp_rd(32'hFFFF_FFFC, 32'hA5A5_0001);
    exp_rd(32'h0000_0000, 32'h5A5A_0002);
    frame(8'h02, 8'h02, 32'hFFFF_FFFC);
    wait_idle("wrap_rd_done");
    ack_dly = 7;
    base = tx_cnt;
    exp_rd(32'h40, pat(32'h40));
    frame(8'h02, 8'h01, 32'h0000_0040);
    n = 0;
    while (tx_cnt < base + 2 && n < 2000) begin
      @(posedge core_clk);
      n++;
    end
    chk("bp_reach", 64'(n < 2000), 64'd1);
    #1 bus.tx_ready = 1'b0;
    repeat (50) @(posedge core_clk);
    #1 bus.tx_ready = 1'b1;
    wait_idle("bp_done");
    chk("stb_hold", 64'(last_run), 64'd7);
    chk("bp_bytes", 64'(tx_cnt - base), 64'd4);
    ack_dly = 1;
    stray = 1'b1;
    repeat (3) @(posedge core_clk);
    #1 stray = 1'b0;
    chk("stray_ack", 64'({busy, bus.wb_cyc_o}), 64'd0);
    send(8'h02);
    send(8'h01);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    core_rstn = 1'b0;
    #2;
    chk("midrst_wb", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o}), 64'd0);
    chk("midrst_misc", 64'({bus.wb_dat_o, bus.tx_valid, bus.tx_data, bus.rx_ready, busy, err}), 64'd0);
    @(posedge core_clk);
    #3 core_rstn = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    exp_rd(32'h20, pat(32'h20));
    frame(8'h02, 8'h01, 32'h0000_0020);
    wait_idle("post_rst_done");
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
    no_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_tx.push_back(8'hDE);
      exp_tx.push_back(8'hAD);
      exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hEF);
    end
    frame(8'h02, 8'h02, 32'h0000_0100);
    wait_idle("tmo_done");
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_len", 64'(last_run), 64'd16);
    no_ack = 1'b0;
    send(8'h02);
    chk("err_clear", 64'(err), 64'd0);
    send(8'h00);
`else
    chk("err_low", 64'(err), 64'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
